cp0_exception_sequencer: RTL and testbench
==========================================

Name: cp0_exception_sequencer

Overview:
- Control FSM that sequences entry into and return from exceptions for the CP0 register block. It sits between the core control unit and CP0.
- Waits for an instruction boundary and drains any in-flight memory operation. It then pulses activeexception into CP0 so that EPC, Cause and Status are latched, flushes the pipeline, and redirects the PC to the exception vector.
- ERET is handled the same way: pulse eret into CP0, then redirect to EPC.
- It is the sole driver of CP0's activeexception and eret inputs.

Parameters:
- EXC_VECTOR, 32'h8000_0180, general exception vector
- INT_VEC_OFFSET, 32'h0000_0200, offset from EXC_VECTOR to the interrupt vector base (vectored mode only)
- VEC_SPACING, 32, byte spacing between vectored interrupt entries

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pendingexception  in  1  from CP0; an exception or enabled interrupt is pending
- exccode  in  5  exception code of the pending exception (0 = interrupt)
- ip_masked  in  8  pending-and-enabled interrupt lines, IP[7:0]
- instr_boundary  in  1  the current instruction retires this cycle
- eret_req  in  1  decoded ERET at the boundary
- mem_busy  in  1  a multicycle load/store is outstanding
- epc  in  32  EPC value read from CP0
- activeexception  out  1  one-cycle pulse to CP0
- eret  out  1  one-cycle pulse to CP0
- stall  out  1  freeze PC and pipeline registers
- flush  out  1  squash the younger instruction
- pc_redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  32  target PC, valid while pc_redirect=1
- busy  out  1  FSM not in RUN

Behaviour:
- States: RUN, DRAIN, ENTER, REDIRECT, ERET_ST. Reset (asynchronous) forces RUN.
- Reset values: all 1-bit outputs 0; redirect_pc = EXC_VECTOR.
- Outputs are Moore-decoded from the state. redirect_pc is registered.
- RUN:
  - If pendingexception && instr_boundary: go to DRAIN when mem_busy, else to ENTER. Capture exccode and ip_masked into an internal register on this transition.
  - Else if eret_req && instr_boundary: capture epc into redirect_pc and go to ERET_ST.
  - Pendingexception takes priority over eret_req when both are asserted in the same cycle.
  - Inputs sampled without instr_boundary are ignored.
- DRAIN: stall=1. Stay while mem_busy=1. On mem_busy=0, go to ENTER. pendingexception dropping during DRAIN does not cancel entry (the captured code is used).
- ENTER: activeexception=1, stall=1, flush=1 for exactly one cycle.
  - Compute redirect_pc from the captured code.
  - Next state is REDIRECT.
- REDIRECT: pc_redirect=1, stall=0, flush=0 for one cycle, then RUN.
- ERET_ST: eret=1, flush=1, pc_redirect=1 for one cycle, redirect_pc = captured epc, then RUN.
- Latencies:
  - Exception entry: boundary → activeexception is 1 cycle; vector fetch follows 2 cycles after the boundary when no drain occurs.
  - ERET: boundary → pc_redirect is 1 cycle.
- A new exception cannot be accepted before the FSM returns to RUN; busy=1 meanwhile.
- Reset asserted mid-sequence aborts immediately with no further pulses. Pulses are never stretched.
- The redirect_pc register holds its last value outside redirect cycles.

Optional Feature:
- CP0_VECTORED_INT_EN defined:
  - For exccode==0, redirect_pc = EXC_VECTOR + INT_VEC_OFFSET + n*VEC_SPACING, where n is the highest set bit index of the captured ip_masked.
  - If the captured ip_masked==0, the general vector is used.
- Not defined: every exception and interrupt uses EXC_VECTOR, and ip_masked is unused.

Decomposition:
- Package cp0_pkg holds:
  - state enum/localparams
  - exccode constants: EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12
  - default vector constants
- One sub-module, cp0_vector_calc: combinational priority encoder plus vector adder, instantiated only under CP0_VECTORED_INT_EN.

Test Plan:
- Syscall entry: pendingexception=1, exccode=8, instr_boundary=1, mem_busy=0 → next cycle activeexception=1 and flush=1; the cycle after, pc_redirect=1 with redirect_pc=0x8000_0180.
- Drain: same stimulus with mem_busy=1 held for 3 cycles → stall=1 for 3 cycles, then activeexception for 1 cycle, then redirect to 0x8000_0180.
- ERET: eret_req=1, epc=0x0040_0120 at a boundary → next cycle eret=1, pc_redirect=1, redirect_pc=0x0040_0120; activeexception stays 0.
- Simultaneous: eret_req=1 and pendingexception=1 (exccode=10) at a boundary → exception path taken; eret never pulses.
- Vectored (macro on): exccode=0, ip_masked=8'b1000_1000 → redirect_pc = 0x8000_0180 + 0x200 + 7*32 = 0x8000_0460. Macro off, same stimulus → 0x8000_0180.
- Reset mid-DRAIN: assert reset while in DRAIN → all outputs 0 asynchronously; no activeexception pulse after reset release.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 exception sequencer.
package cp0_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ENTER    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERET     = 3'd4
  } seq_state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [31:0] DEF_EXC_VECTOR     = 32'h8000_0180;
  localparam logic [31:0] DEF_INT_VEC_OFFSET = 32'h0000_0200;
  localparam logic [31:0] DEF_VEC_SPACING    = 32'd32;

endpackage

// File: rtl/cp0_vector_calc.sv
// Exception vector computation for vectored interrupt mode: the highest pending
// interrupt line selects its own entry above the interrupt vector base.
module cp0_vector_calc
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = DEF_EXC_VECTOR,
  parameter logic [31:0] INT_VEC_OFFSET = DEF_INT_VEC_OFFSET,
  parameter logic [31:0] VEC_SPACING    = DEF_VEC_SPACING
) (
  input  logic [4:0]  exccode,
  input  logic [7:0]  ip,
  output logic [31:0] vector
);

  logic [2:0] top_line;
  logic       any_line;

  // Ascending scan so the last hit is the highest set line.
  always_comb begin
    top_line = 3'd0;
    any_line = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ip[i]) begin
        top_line = 3'(i);
        any_line = 1'b1;
      end
    end
  end

  always_comb begin
    vector = EXC_VECTOR;
    if (exccode == EXC_INT && any_line) begin
      vector = EXC_VECTOR + INT_VEC_OFFSET + ({29'd0, top_line} * VEC_SPACING);
    end
  end

endmodule

// File: rtl/cp0_exception_sequencer.sv
// Sequences exception entry and ERET return between the core control unit and CP0.
// Define CP0_VECTORED_INT_EN to route interrupts to per-line vectors.
module cp0_exception_sequencer
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = DEF_EXC_VECTOR,
  parameter logic [31:0] INT_VEC_OFFSET = DEF_INT_VEC_OFFSET,
  parameter logic [31:0] VEC_SPACING    = DEF_VEC_SPACING
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [7:0]  ip_masked,
  input  logic        instr_boundary,
  input  logic        eret_req,
  input  logic        mem_busy,
  input  logic [31:0] epc,
  output logic        activeexception,
  output logic        eret,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  seq_state_t  state_reg, state_next;
  logic [4:0]  code_reg;
  logic [7:0]  ip_reg;
  logic        capture;
  logic        take_eret;
  logic [31:0] vector;

`ifdef CP0_VECTORED_INT_EN
  cp0_vector_calc #(
    .EXC_VECTOR     (EXC_VECTOR),
    .INT_VEC_OFFSET (INT_VEC_OFFSET),
    .VEC_SPACING    (VEC_SPACING)
  ) u_vector_calc (
    .exccode (code_reg),
    .ip      (ip_reg),
    .vector  (vector)
  );
`else
  logic unused_capture;
  assign unused_capture = ^{code_reg, ip_reg};
  assign vector = EXC_VECTOR;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Exception beats ERET when both arrive at the same boundary.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    take_eret  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (pendingexception && instr_boundary) begin
          capture    = 1'b1;
          state_next = mem_busy ? ST_DRAIN : ST_ENTER;
        end else if (eret_req && instr_boundary) begin
          take_eret  = 1'b1;
          state_next = ST_ERET;
        end
      end
      ST_DRAIN:    if (!mem_busy) state_next = ST_ENTER;
      ST_ENTER:    state_next = ST_REDIRECT;
      ST_REDIRECT: state_next = ST_RUN;
      ST_ERET:     state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  always_comb begin
    activeexception = 1'b0;
    eret            = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    pc_redirect     = 1'b0;
    busy            = (state_reg != ST_RUN);
    case (state_reg)
      ST_DRAIN: stall = 1'b1;
      ST_ENTER: begin
        activeexception = 1'b1;
        stall           = 1'b1;
        flush           = 1'b1;
      end
      ST_REDIRECT: pc_redirect = 1'b1;
      ST_ERET: begin
        eret        = 1'b1;
        flush       = 1'b1;
        pc_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_reg <= EXC_INT;
      ip_reg   <= 8'd0;
    end else if (capture) begin
      code_reg <= exccode;
      ip_reg   <= ip_masked;
    end
  end

  // Vector is loaded while in ENTER so it is stable during the REDIRECT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc <= EXC_VECTOR;
    end else if (take_eret) begin
      redirect_pc <= epc;
    end else if (state_reg == ST_ENTER) begin
      redirect_pc <= vector;
    end
  end

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Scoreboard bench for cp0_exception_sequencer: expected output cycles are queued
// as each scenario is launched and compared one per clock.
module tb_cp0_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pendingexception;
  logic [4:0]  exccode;
  logic [7:0]  ip_masked;
  logic        instr_boundary;
  logic        eret_req;
  logic        mem_busy;
  logic [31:0] epc;
  logic        activeexception;
  logic        eret;
  logic        stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  cp0_exception_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pendingexception (pendingexception),
    .exccode          (exccode),
    .ip_masked        (ip_masked),
    .instr_boundary   (instr_boundary),
    .eret_req         (eret_req),
    .mem_busy         (mem_busy),
    .epc              (epc),
    .activeexception  (activeexception),
    .eret             (eret),
    .stall            (stall),
    .flush            (flush),
    .pc_redirect      (pc_redirect),
    .redirect_pc      (redirect_pc),
    .busy             (busy)
  );

  // Flag order: {busy, activeexception, eret, stall, flush, pc_redirect}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_DRAIN = 6'b100100;
  localparam logic [5:0] F_ENTER = 6'b110110;
  localparam logic [5:0] F_REDIR = 6'b100001;
  localparam logic [5:0] F_ERET  = 6'b101011;
  localparam logic [31:0] GEN_VEC = 32'h8000_0180;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  string       scen;
  logic [31:0] last_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s/%s cyc=%0d got=%h want=%h", scen, tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [5:0] flags();
    return {busy, activeexception, eret, stall, flush, pc_redirect};
  endfunction

  task automatic push(input logic [5:0] f, input logic [31:0] pc);
    exp_t e;
    e.f  = f;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  // One clock: one-shot request inputs drop after the edge, then one expectation is retired.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    instr_boundary   = 1'b0;
    pendingexception = 1'b0;
    eret_req         = 1'b0;
    exccode          = 5'($urandom_range(0, 31));
    ip_masked        = 8'($urandom_range(0, 255));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("flags", 64'(flags()), 64'(e.f));
      check("pc", 64'(redirect_pc), 64'(e.pc));
      $display("txn %s cyc=%0d flags=%b pc=%h", scen, cyc, flags(), redirect_pc);
    end
  endtask

  task automatic exc_entry(input string name, input logic [4:0] code, input logic [7:0] ip,
                           input logic with_eret, input int drain, input logic [31:0] vec);
    scen             = name;
    pendingexception = 1'b1;
    exccode          = code;
    ip_masked        = ip;
    instr_boundary   = 1'b1;
    eret_req         = with_eret;
    epc              = 32'hDEAD_BEE0;
    mem_busy         = (drain > 0);
    for (int i = 0; i < drain; i++) push(F_DRAIN, last_pc);
    push(F_ENTER, last_pc);
    push(F_REDIR, vec);
    push(F_IDLE, vec);
    last_pc = vec;
    for (int k = 1; k <= drain + 3; k++) begin
      step();
      mem_busy = (k < drain);
    end
  endtask

  task automatic eret_seq(input logic [31:0] target);
    scen           = "eret";
    eret_req       = 1'b1;
    epc            = target;
    instr_boundary = 1'b1;
    mem_busy       = 1'b0;
    push(F_ERET, target);
    push(F_IDLE, target);
    last_pc = target;
    step();
    step();
  endtask

  initial begin
    reset            = 1'b1;
    pendingexception = 1'b0;
    exccode          = 5'd0;
    ip_masked        = 8'd0;
    instr_boundary   = 1'b0;
    eret_req         = 1'b0;
    mem_busy         = 1'b0;
    epc              = 32'd0;
    last_pc          = GEN_VEC;
    scen             = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("flags", 64'(flags()), 64'(F_IDLE));
    check("pc", 64'(redirect_pc), 64'(GEN_VEC));
    reset = 1'b0;

    exc_entry("syscall", 5'd8, 8'h00, 1'b0, 0, GEN_VEC);
    exc_entry("drain", 5'd12, 8'h00, 1'b0, 3, GEN_VEC);
    eret_seq(32'h0040_0120);
    exc_entry("simul", 5'd10, 8'h00, 1'b1, 0, GEN_VEC);
    eret_seq(32'h0040_0AA4);

    // Requests without an instruction boundary must be ignored.
    scen             = "noboundary";
    pendingexception = 1'b1;
    eret_req         = 1'b1;
    epc              = 32'h1234_5678;
    instr_boundary   = 1'b0;
    push(F_IDLE, last_pc);
    push(F_IDLE, last_pc);
    step();
    step();

`ifdef CP0_VECTORED_INT_EN
    exc_entry("vec_ip7", 5'd0, 8'b1000_1000, 1'b0, 0, 32'h8000_0460);
    exc_entry("vec_ip0", 5'd0, 8'b0000_0001, 1'b0, 1, 32'h8000_0380);
    exc_entry("vec_nonint", 5'd8, 8'b1000_0000, 1'b0, 0, GEN_VEC);
`else
    exc_entry("vec_ip7", 5'd0, 8'b1000_1000, 1'b0, 0, GEN_VEC);
`endif
    exc_entry("vec_none", 5'd0, 8'h00, 1'b0, 0, GEN_VEC);
    eret_seq(32'h0040_0300);

    // Asynchronous reset while draining: outputs clear mid-cycle, no late pulse.
    scen             = "rst_drain";
    pendingexception = 1'b1;
    exccode          = 5'd8;
    instr_boundary   = 1'b1;
    mem_busy         = 1'b1;
    push(F_DRAIN, last_pc);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_flags", 64'(flags()), 64'(F_IDLE));
    check("async_pc", 64'(redirect_pc), 64'(GEN_VEC));
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_busy = 1'b0;
    last_pc  = GEN_VEC;
    repeat (3) push(F_IDLE, last_pc);
    repeat (3) step();

    scen = "end";
    check("queue_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
